uart_rx: RTL
============

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the downstream counterpart of the UART transmitter: it consumes the serial line the transmitter drives and presents received bytes to the peripheral bus logic through a held data register with a valid/read handshake. It oversamples 16x with a 3-sample majority vote, rejects start-bit glitches, and flags framing errors and overruns.

Parameters:
BUS_CLK, 40_000_000, bus clock frequency in Hz
BAUD, 9600, BAUD rate
OVERSAMPLE, 16, samples per bit; fixed at 16, other values unsupported
TICK_DIV, BUS_CLK/(BAUD*OVERSAMPLE), derived localparam; integer-truncated (260 at defaults)

Ports:
clk  input  1  bus clock
rst_n  input  1  reset, asynchronous, active-low
rx  input  1  RX serial input, asynchronous to clk, idle high
din  output  8  last received byte, held until overwritten
valid  output  1  high while din holds an unread byte
read  input  1  pulse for one bus clock cycle to consume din (clears valid)
busy  output  1  high from start-edge detection until frame end or abort
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: byte completed while valid was still set

Behaviour:
- Reset (async, rst_n=0): din=0, valid=0, busy=0, frame_err=0, overrun=0; state=IDLE; synchronizer flops=1; all counters=0. Reset mid-frame aborts the frame with no output pulses.
- rx passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value rx_s, which lags rx by 2 clk.
- Tick generator: runs only when state!=IDLE; counts 0..TICK_DIV-1; tick=1 when count==TICK_DIV-1; restarts at 0 on entry from IDLE.
- sample_cnt 0..15 advances on each tick and wraps. rx_s is captured into three vote bits at sample_cnt 7, 8 and 9. The bit value is the majority of the three, decided on the tick where sample_cnt==9.
- FSM (IDLE, START, DATA, STOP, WAIT_IDLE):
  - IDLE: busy=0. A falling edge of rx_s (previous 1, current 0) moves to START the next cycle with busy=1 and sample_cnt=0.
  - START: at the sample_cnt==9 decision, a majority of 1 is a glitch: go to IDLE with no pulses. A majority of 0 proceeds, and at the sample_cnt==15 tick the FSM enters DATA with bit_idx=0.
  - DATA: at each sample_cnt==9 decision, shift[bit_idx] takes the majority. At the sample_cnt==15 tick, bit_idx increments; after bit_idx==7 the FSM enters STOP.
  - STOP: at the sample_cnt==9 decision, a majority of 1 loads din from shift and asserts valid the following cycle, then goes to IDLE. A majority of 0 discards the byte, pulses frame_err, and goes to WAIT_IDLE.
  - WAIT_IDLE: busy=1; returns to IDLE when rx_s==1. This absorbs break conditions; no new frame starts while the line is held low.
- STOP completes mid-bit, so back-to-back frames whose next start edge follows immediately are received correctly.
- Handshake:
  - read while valid clears valid on the next cycle. read while !valid is ignored. din is not cleared by read.
  - Byte completes while valid=1 and read=0: din is overwritten, valid stays 1, overrun pulses.
  - Byte completes in the same cycle as read: the new byte wins, valid stays 1, no overrun.
- Latency: valid rises 2 (sync) + ~9.5 bit times + 1 cycle after the rx falling edge.
- frame_err and overrun are exactly one clk wide and never asserted at the same time; a framing error does not touch din or valid.

Test Plan:
Use BUS_CLK=1_600_000, BAUD=10_000 (TICK_DIV=10, 160 clk/bit).
- Single byte: drive 0xA5 frame on rx -> valid rises ~1522 clk after start edge, din=0xA5, busy falls, no error pulses; read -> valid=0 next cycle.
- Back-to-back: 0x00, 0xFF, 0x3C with no idle gap, reading each -> three bytes received in order, no frame_err/overrun.
- Glitch: rx low for 40 clk then high -> busy pulses then returns to IDLE, valid stays 0, no pulses.
- Framing error: 0x55 with stop bit driven 0, then line low for 3 bit times, then high -> frame_err one pulse, valid=0, busy held until rx high, then 0x81 received correctly.
- Overrun: send 0x12 and 0x34 without read -> overrun one pulse, din=0x34, valid=1. Repeat with read asserted on the completion cycle -> no overrun.
- Reset mid-frame: assert rst_n=0 asynchronously during DATA bit 4 -> all outputs 0 immediately. Release, send 0x7E -> din=0x7E.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled with a 3-sample majority vote.
// Received bytes are held in din with a valid/read handshake.
module uart_rx #(
    parameter int BUS_CLK    = 40_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] din,
    output logic       valid,
    input  logic       read,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int TICK_DIV = BUS_CLK / (BAUD * OVERSAMPLE);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic          rx_m;
    logic          rx_s;
    logic          rx_prev;
    logic [TW-1:0] tick_cnt;
    logic [3:0]    sample_cnt;
    logic [2:0]    bit_idx;
    logic          vote0;
    logic          vote1;
    logic [7:0]    shift;

    logic tick;
    logic decide;
    logic last;
    logic maj;
    logic load;
    logic ferr;

    // Two-flop synchronizer; idle-high reset so no false start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_m    <= rx;
            rx_s    <= rx_m;
            rx_prev <= rx_s;
        end
    end

    assign tick   = (state != IDLE) && (tick_cnt == TICK_LAST);
    assign decide = tick && (sample_cnt == 4'd9);
    assign last   = tick && (sample_cnt == 4'd15);
    assign maj    = (vote0 & vote1) | (vote0 & rx_s) | (vote1 & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ferr      = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (rx_prev && !rx_s) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (decide && maj) begin
                    state_nxt = IDLE;
                end else if (last) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (last && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (decide) begin
                    if (maj) begin
                        load      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        ferr      = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Counters sit at zero in IDLE so every frame starts phase-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
        end else if (state == IDLE) begin
            tick_cnt   <= '0;
            sample_cnt <= 4'd0;
        end else if (tick) begin
            tick_cnt   <= '0;
            sample_cnt <= sample_cnt + 4'd1;
        end else begin
            tick_cnt   <= tick_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_idx <= 3'd0;
        end else if (state != DATA) begin
            bit_idx <= 3'd0;
        end else if (last) begin
            bit_idx <= bit_idx + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote0 <= 1'b0;
            vote1 <= 1'b0;
        end else if (tick) begin
            if (sample_cnt == 4'd7) begin
                vote0 <= rx_s;
            end
            if (sample_cnt == 4'd8) begin
                vote1 <= rx_s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= 8'd0;
        end else if ((state == DATA) && decide) begin
            shift[bit_idx] <= maj;
        end
    end

    // A completing byte always wins over a same-cycle read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din       <= 8'd0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= ferr;
            overrun   <= load && valid && !read;
            if (load) begin
                din   <= shift;
                valid <= 1'b1;
            end else if (read) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
